// File: rtl/hpdcache_refill_ctrl.sv
// rtl/hpdcache_refill_ctrl.sv - refill handler: collects memory beats, acks the MSHR, emits refill write and core response
// One line in flight; outputs are forced to 0 while rst_i is high.
module hpdcache_refill_ctrl #(
    parameter int MSHR_SET_WIDTH = 6,
    parameter int MSHR_WAY_WIDTH = 2,
    parameter int NLINE_WIDTH    = 34,
    parameter int TID_WIDTH      = 6,
    parameter int SID_WIDTH      = 3,
    parameter int BEATS          = 4,
    parameter int BEAT_WIDTH     = 64,
    parameter int WORD_WIDTH     = $clog2(BEATS)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   mem_rsp_valid_i,
    output logic                                   mem_rsp_ready_o,
    input  logic [MSHR_WAY_WIDTH+MSHR_SET_WIDTH-1:0] mem_rsp_id_i,
    input  logic [BEAT_WIDTH-1:0]                  mem_rsp_data_i,
    input  logic                                   mem_rsp_last_i,
    input  logic                                   mem_rsp_error_i,
    output logic                                   mshr_ack_req_o,
    input  logic                                   mshr_ack_gnt_i,
    output logic                                   mshr_ack_o,
    output logic                                   mshr_ack_cs_o,
    output logic [MSHR_SET_WIDTH-1:0]              mshr_ack_set_o,
    output logic [MSHR_WAY_WIDTH-1:0]              mshr_ack_way_o,
    input  logic [TID_WIDTH-1:0]                   mshr_req_id_i,
    input  logic [SID_WIDTH-1:0]                   mshr_src_id_i,
    input  logic [NLINE_WIDTH-1:0]                 mshr_nline_i,
    input  logic [WORD_WIDTH-1:0]                  mshr_word_i,
    input  logic                                   mshr_need_rsp_i,
    input  logic                                   mshr_is_prefetch_i,
    output logic                                   refill_valid_o,
    input  logic                                   refill_ready_i,
    output logic [NLINE_WIDTH-1:0]                 refill_nline_o,
    output logic [BEATS*BEAT_WIDTH-1:0]            refill_data_o,
    output logic                                   refill_error_o,
    output logic                                   core_rsp_valid_o,
    input  logic                                   core_rsp_ready_i,
    output logic [TID_WIDTH-1:0]                   core_rsp_tid_o,
    output logic [SID_WIDTH-1:0]                   core_rsp_sid_o,
    output logic [BEAT_WIDTH-1:0]                  core_rsp_data_o,
    output logic                                   core_rsp_error_o
);

    localparam int ID_WIDTH   = MSHR_WAY_WIDTH + MSHR_SET_WIDTH;
    localparam int LINE_WIDTH = BEATS * BEAT_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_ACK,
        ST_META,
        ST_OUT
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   cnt_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [LINE_WIDTH-1:0]   line_q;
    logic                    err_q;
    logic                    refill_done_q;
    logic                    rsp_done_q;
    logic [TID_WIDTH-1:0]    tid_q;
    logic [SID_WIDTH-1:0]    sid_q;
    logic [NLINE_WIDTH-1:0]  nline_q;
    logic [WORD_WIDTH-1:0]   word_q;
    logic                    need_rsp_q;
    logic                    prefetch_q;

    logic collecting;
    logic beat_acc;
    logic at_max;
    logic line_end;
    logic rsp_needed;
    logic refill_hs;
    logic rsp_hs;

    assign collecting      = ~rst_i & ((state_q == ST_IDLE) | (state_q == ST_COLLECT));
    assign mem_rsp_ready_o = collecting;
    assign beat_acc        = mem_rsp_valid_i & collecting;
    assign at_max          = (cnt_q == WORD_WIDTH'(BEATS - 1));
    // A line ends on an explicit last or when the buffer is full, whichever is first
    assign line_end        = beat_acc & (mem_rsp_last_i | at_max);
    assign rsp_needed      = need_rsp_q & ~prefetch_q;

    always_comb begin
        state_d          = state_q;
        mshr_ack_req_o   = 1'b0;
        mshr_ack_o       = 1'b0;
        mshr_ack_cs_o    = 1'b0;
        mshr_ack_set_o   = '0;
        mshr_ack_way_o   = '0;
        refill_valid_o   = 1'b0;
        refill_nline_o   = '0;
        refill_data_o    = '0;
        refill_error_o   = 1'b0;
        core_rsp_valid_o = 1'b0;
        core_rsp_tid_o   = '0;
        core_rsp_sid_o   = '0;
        core_rsp_data_o  = '0;
        core_rsp_error_o = 1'b0;
        refill_hs        = 1'b0;
        rsp_hs           = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (beat_acc) state_d = line_end ? ST_ACK : ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (line_end) state_d = ST_ACK;
                end
                ST_ACK: begin
                    mshr_ack_req_o = 1'b1;
                    mshr_ack_o     = mshr_ack_gnt_i;
                    mshr_ack_cs_o  = mshr_ack_gnt_i;
                    mshr_ack_way_o = id_q[ID_WIDTH-1 -: MSHR_WAY_WIDTH];
                    mshr_ack_set_o = id_q[MSHR_SET_WIDTH-1:0];
                    if (mshr_ack_gnt_i) state_d = ST_META;
                end
                ST_META: begin
                    state_d = ST_OUT;
                end
                ST_OUT: begin
                    refill_valid_o   = ~refill_done_q;
                    refill_nline_o   = nline_q;
                    refill_data_o    = line_q;
                    refill_error_o   = err_q;
                    core_rsp_valid_o = rsp_needed & ~rsp_done_q;
                    core_rsp_tid_o   = tid_q;
                    core_rsp_sid_o   = sid_q;
                    core_rsp_data_o  = line_q[32'(word_q)*BEAT_WIDTH +: BEAT_WIDTH];
                    core_rsp_error_o = err_q;
                    refill_hs        = ~refill_done_q & refill_ready_i;
                    rsp_hs           = rsp_needed & ~rsp_done_q & core_rsp_ready_i;
                    if ((refill_done_q | refill_hs) & (~rsp_needed | rsp_done_q | rsp_hs))
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            refill_done_q <= 1'b0;
            rsp_done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (beat_acc) begin
                line_q[32'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rsp_data_i;
                cnt_q <= cnt_q + 1'b1;
                if (state_q == ST_IDLE) id_q <= mem_rsp_id_i;
                // Short or long lines are flagged as errors
                err_q <= err_q | mem_rsp_error_i | (line_end & (mem_rsp_last_i ^ at_max));
            end
            if (state_q == ST_META) begin
                tid_q      <= mshr_req_id_i;
                sid_q      <= mshr_src_id_i;
                nline_q    <= mshr_nline_i;
                word_q     <= mshr_word_i;
                need_rsp_q <= mshr_need_rsp_i;
                prefetch_q <= mshr_is_prefetch_i;
            end
            if (refill_hs) refill_done_q <= 1'b1;
            if (rsp_hs) rsp_done_q <= 1'b1;
            if ((state_q == ST_OUT) && (state_d == ST_IDLE)) begin
                cnt_q         <= '0;
                err_q         <= 1'b0;
                refill_done_q <= 1'b0;
                rsp_done_q    <= 1'b0;
            end
        end
    end

endmodule
